legv8_op_sequencer: RTL and testbench
=====================================

Name: legv8_op_sequencer

Overview:
- Command-driven controller for the LEGv8 datapath.
- Accepts one macro-operation at a time over a valid/ready handshake and drives the datapath's 25-bit ControlWord and 64-bit constant, one word per clock.
- Multi-cycle ops (LDUR) are sequenced internally.
- Captures ALU status for flag-setting ops and reports completion and illegal opcodes.

Parameters:
- IDLE_CW, 25'b0, control word driven when no op is executing (no writes, no bus enables).

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  sequencer can accept a command this cycle
- cmd_op  input  4  opcode (see Behaviour)
- cmd_rd  input  5  destination / store-source register
- cmd_rn  input  5  first source / base register
- cmd_rm  input  5  second source register
- cmd_imm  input  64  immediate, offset or shift amount
- status  input  4  datapath ALU status, combinational from current ControlWord
- ControlWord  output  25  {SA[24:20], SB[19:15], DA[14:10], RegWrite[9], MemWrite[8], FS[7:3], Bsel[2], EN_Mem[1], EN_ALU[0]}
- constant  output  64  datapath immediate bus
- flags  output  4  status latched by ADDS/SUBS, same bit order as status
- done  output  1  one-cycle pulse, coincident with an op's final control word
- err  output  1  one-cycle pulse for an illegal opcode
- busy  output  1  a multi-cycle op is in progress

Behaviour:
- Reset (reset=0, asynchronous):
  - ControlWord=IDLE_CW, constant=0, flags=0, done=0, err=0, busy=0, state=IDLE.
  - Any in-flight op is discarded with no further words issued.
- Handshake:
  - A command is accepted on a rising edge with cmd_valid&&cmd_ready.
  - cmd_ready=1 in IDLE and EXEC; cmd_ready=0 in LD_ADDR.
  - Back-to-back single-cycle ops therefore issue one word per clock.
- Latency: the first control word of an accepted op is registered and presented the cycle after acceptance. With no new accept, the next cycle reverts to IDLE_CW and constant=0.
- FS codes: AND 00000, ORR 00100, ADD 01000, EOR 01100, SUB 01010, LSL 10000, LSR 10100.
- Register-register ops (2 ADD, 3 SUB, 4 AND, 5 ORR, 6 EOR):
  - SA=rn, SB=rm, DA=rd, RegWrite=1, Bsel=0, EN_ALU=1, constant=0.
- Register-immediate ops (7 ADDI, 8 SUBI, 9 LSL, 10 LSR):
  - SA=rn, DA=rd, RegWrite=1, Bsel=1, EN_ALU=1, constant=imm.
  - For LSL/LSR, constant={58'b0, imm[5:0]}.
- Op 0 NOP: one cycle of IDLE_CW with done=1.
- Op 1 MOVI: SA=31, SB=0, DA=rd, RegWrite=1, FS=ADD, Bsel=1, EN_ALU=1, constant=imm.
- Op 11 STUR: SA=rn, SB=rd, DA=0, MemWrite=1, FS=ADD, Bsel=1, EN_Mem=1, EN_ALU=0, constant=imm.
- Op 12 LDUR takes two cycles, driven by FSM IDLE -> EXEC -> LD_ADDR -> LD_WB:
  - Address cycle: SA=rn, FS=ADD, Bsel=1, constant=imm, all write/enable bits 0, busy=1, state LD_ADDR.
  - Writeback cycle: same SA/FS/Bsel/constant, DA=rd, RegWrite=1, EN_Mem=1, EN_ALU=0, done=1, state LD_WB.
  - The next accept is allowed in the writeback cycle.
- Ops 13 ADDS / 14 SUBS:
  - Same word as ADD/SUB.
  - flags<=status at the clock edge ending that word's cycle.
  - flags are unchanged by all other ops.
- Op 15 is illegal:
  - Datapath gets IDLE_CW; err=1 and done=0 for one cycle.
  - The sequencer stays ready.
- Register 31 is passed through unchanged in any field.
- done fires exactly once per legal op.
- cmd_* inputs are sampled only at accept; changes while cmd_ready=0 have no effect.

Decomposition:
- Package legv8_ctrl_pkg holds:
  - opcode constants (4-bit)
  - FS constants
  - ControlWord field bit positions
  - IDLE_CW value
  - FSM state typedef {IDLE, EXEC, LD_ADDR, LD_WB}
- One sub-module, legv8_cw_encode: purely combinational, packing the fields {SA, SB, DA, RegWrite, MemWrite, FS, Bsel, EN_Mem, EN_ALU} into the 25-bit word.

Test Plan:
- Reset low then high; accept MOVI rd=5, imm=4 -> next cycle ControlWord=25'b1111100000001011001000101, constant=4, done=1; following cycle ControlWord=0.
- Accept ADD rd=5, rn=2, rm=0 then SUB rd=30, rn=15, rm=12 on consecutive cycles -> words 25'b0001000000001011001000001 and 25'b0111101100111101001010001 on consecutive cycles, cmd_ready held 1.
- Accept STUR rd=2, rn=1, imm=0 -> ControlWord=25'b0000100010000000101000110, done=1.
- Accept LDUR rd=3, rn=1, imm=8 with cmd_valid held -> cmd_ready=0 during the address cycle, which has constant=8 and RegWrite=0. The writeback cycle has DA=3, RegWrite=1, EN_Mem=1, done=1. The held command is accepted in the writeback cycle.
- SUBS rd=0, rn=15, rm=15 with status forced to 4'b1001 -> flags=4'b1001 after that cycle; a following ADD with status=4'b0000 leaves flags=4'b1001.
- Opcode 15 -> err pulse, ControlWord=0, no done. Assert reset mid-LDUR (in LD_ADDR) -> ControlWord=0, busy=0 immediately; no writeback word issued.

Source files
------------

// File: rtl/legv8_ctrl_pkg.sv
// Shared constants and types for the LEGv8 op sequencer: opcodes, ALU function
// selects, ControlWord field layout, FSM state encoding and a field bundle type.
package legv8_ctrl_pkg;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_MOVI = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_ORR  = 4'd5;
  localparam logic [3:0] OP_EOR  = 4'd6;
  localparam logic [3:0] OP_ADDI = 4'd7;
  localparam logic [3:0] OP_SUBI = 4'd8;
  localparam logic [3:0] OP_LSL  = 4'd9;
  localparam logic [3:0] OP_LSR  = 4'd10;
  localparam logic [3:0] OP_STUR = 4'd11;
  localparam logic [3:0] OP_LDUR = 4'd12;
  localparam logic [3:0] OP_ADDS = 4'd13;
  localparam logic [3:0] OP_SUBS = 4'd14;
  localparam logic [3:0] OP_ILL  = 4'd15;

  localparam logic [4:0] FS_AND = 5'b00000;
  localparam logic [4:0] FS_ORR = 5'b00100;
  localparam logic [4:0] FS_ADD = 5'b01000;
  localparam logic [4:0] FS_EOR = 5'b01100;
  localparam logic [4:0] FS_SUB = 5'b01010;
  localparam logic [4:0] FS_LSL = 5'b10000;
  localparam logic [4:0] FS_LSR = 5'b10100;

  localparam int CW_SA_LSB   = 20;
  localparam int CW_SB_LSB   = 15;
  localparam int CW_DA_LSB   = 10;
  localparam int CW_REGWRITE = 9;
  localparam int CW_MEMWRITE = 8;
  localparam int CW_FS_LSB   = 3;
  localparam int CW_BSEL     = 2;
  localparam int CW_EN_MEM   = 1;
  localparam int CW_EN_ALU   = 0;

  localparam logic [24:0] IDLE_CW = 25'b0;

  typedef logic [1:0] state_t;
  localparam state_t IDLE    = 2'd0;
  localparam state_t EXEC    = 2'd1;
  localparam state_t LD_ADDR = 2'd2;
  localparam state_t LD_WB   = 2'd3;

  typedef struct packed {
    logic [4:0] sa;
    logic [4:0] sb;
    logic [4:0] da;
    logic       reg_write;
    logic       mem_write;
    logic [4:0] fs;
    logic       bsel;
    logic       en_mem;
    logic       en_alu;
  } cw_fields_t;

  // ALU function select for the register-register and register-immediate ops.
  function automatic logic [4:0] op_fs(input logic [3:0] op);
    case (op)
      OP_AND:                  op_fs = FS_AND;
      OP_ORR:                  op_fs = FS_ORR;
      OP_EOR:                  op_fs = FS_EOR;
      OP_SUB, OP_SUBS, OP_SUBI: op_fs = FS_SUB;
      OP_LSL:                  op_fs = FS_LSL;
      OP_LSR:                  op_fs = FS_LSR;
      default:                 op_fs = FS_ADD;
    endcase
  endfunction

endpackage

// File: rtl/legv8_cw_encode.sv
// Packs the individual datapath control fields into the 25-bit ControlWord.
module legv8_cw_encode
  import legv8_ctrl_pkg::*;
(
  input  cw_fields_t  fields,
  output logic [24:0] cw
);

  always_comb begin
    // NOTE: a full default ahead of the field writes keeps this purely combinational (no latch).
    cw = IDLE_CW;
    cw[CW_SA_LSB +: 5] = fields.sa;
    cw[CW_SB_LSB +: 5] = fields.sb;
    cw[CW_DA_LSB +: 5] = fields.da;
    cw[CW_REGWRITE]    = fields.reg_write;
    cw[CW_MEMWRITE]    = fields.mem_write;
    cw[CW_FS_LSB +: 5] = fields.fs;
    cw[CW_BSEL]        = fields.bsel;
    cw[CW_EN_MEM]      = fields.en_mem;
    cw[CW_EN_ALU]      = fields.en_alu;
  end

endmodule

// File: rtl/legv8_op_sequencer.sv
// Command-driven LEGv8 datapath controller: accepts one macro-op per handshake and
// issues registered control words, sequencing LDUR over an address and a writeback cycle.
module legv8_op_sequencer
  import legv8_ctrl_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic [4:0]  cmd_rd,
  input  logic [4:0]  cmd_rn,
  input  logic [4:0]  cmd_rm,
  input  logic [63:0] cmd_imm,
  input  logic [3:0]  status,
  output logic [24:0] ControlWord,
  output logic [63:0] constant,
  output logic [3:0]  flags,
  output logic        done,
  output logic        err,
  output logic        busy
);

  state_t      state, state_nxt;
  cw_fields_t  fields_nxt;
  logic [24:0] cw_nxt;
  logic [63:0] const_nxt;
  logic        done_nxt, err_nxt, busy_nxt;
  logic        flag_pend, flag_pend_nxt;
  logic [4:0]  ld_rd;
  logic        accept;

  assign cmd_ready = (state != LD_ADDR);
  assign accept    = cmd_valid && cmd_ready;

  legv8_cw_encode u_encode (
    .fields (fields_nxt),
    .cw     (cw_nxt)
  );

  always_comb begin
    fields_nxt    = '0;
    const_nxt     = '0;
    state_nxt     = IDLE;
    done_nxt      = 1'b0;
    err_nxt       = 1'b0;
    busy_nxt      = 1'b0;
    flag_pend_nxt = 1'b0;

    if (state == LD_ADDR) begin
      // Address word still on the bus carries base register and offset into writeback.
      fields_nxt.sa        = ControlWord[CW_SA_LSB +: 5];
      fields_nxt.da        = ld_rd;
      fields_nxt.reg_write = 1'b1;
      fields_nxt.fs        = FS_ADD;
      fields_nxt.bsel      = 1'b1;
      fields_nxt.en_mem    = 1'b1;
      const_nxt            = constant;
      state_nxt            = LD_WB;
      done_nxt             = 1'b1;
    end else if (accept) begin
      state_nxt = EXEC;
      done_nxt  = 1'b1;
      case (cmd_op)
        OP_NOP: ;
        OP_MOVI: begin
          fields_nxt.sa        = 5'd31;
          fields_nxt.da        = cmd_rd;
          fields_nxt.reg_write = 1'b1;
          fields_nxt.fs        = FS_ADD;
          fields_nxt.bsel      = 1'b1;
          fields_nxt.en_alu    = 1'b1;
          const_nxt            = cmd_imm;
        end
        OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_EOR, OP_ADDS, OP_SUBS: begin
          fields_nxt.sa        = cmd_rn;
          fields_nxt.sb        = cmd_rm;
          fields_nxt.da        = cmd_rd;
          fields_nxt.reg_write = 1'b1;
          fields_nxt.fs        = op_fs(cmd_op);
          fields_nxt.en_alu    = 1'b1;
          flag_pend_nxt        = (cmd_op == OP_ADDS) || (cmd_op == OP_SUBS);
        end
        OP_ADDI, OP_SUBI, OP_LSL, OP_LSR: begin
          fields_nxt.sa        = cmd_rn;
          fields_nxt.da        = cmd_rd;
          fields_nxt.reg_write = 1'b1;
          fields_nxt.fs        = op_fs(cmd_op);
          fields_nxt.bsel      = 1'b1;
          fields_nxt.en_alu    = 1'b1;
          const_nxt            = (cmd_op == OP_LSL || cmd_op == OP_LSR) ?
                                 {58'b0, cmd_imm[5:0]} : cmd_imm;
        end
        OP_STUR: begin
          fields_nxt.sa        = cmd_rn;
          fields_nxt.sb        = cmd_rd;
          fields_nxt.mem_write = 1'b1;
          fields_nxt.fs        = FS_ADD;
          fields_nxt.bsel      = 1'b1;
          fields_nxt.en_mem    = 1'b1;
          const_nxt            = cmd_imm;
        end
        OP_LDUR: begin
          fields_nxt.sa = cmd_rn;
          fields_nxt.fs = FS_ADD;
          fields_nxt.bsel = 1'b1;
          const_nxt     = cmd_imm;
          state_nxt     = LD_ADDR;
          done_nxt      = 1'b0;
          busy_nxt      = 1'b1;
        end
        default: begin
          done_nxt = 1'b0;
          err_nxt  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      ControlWord <= IDLE_CW;
      constant    <= '0;
      flags       <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
      busy        <= 1'b0;
      flag_pend   <= 1'b0;
      ld_rd       <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state       <= state_nxt;
      ControlWord <= cw_nxt;
      constant    <= const_nxt;
      done        <= done_nxt;
      err         <= err_nxt;
      busy        <= busy_nxt;
      flag_pend   <= flag_pend_nxt;
      // Status reflects the ADDS/SUBS word that is on the bus during this cycle.
      if (flag_pend) flags <= status;
      if (accept && cmd_op == OP_LDUR) ld_rd <= cmd_rd;
    end
  end

endmodule

// File: tb/tb_legv8_op_sequencer.sv
// Scoreboard bench for legv8_op_sequencer: the driver pushes expected words built from
// the op rules; a negedge monitor pops and compares whenever the DUT presents output.
module tb_legv8_op_sequencer;

  typedef struct packed {
    logic [24:0] cw;
    logic [63:0] k;
    logic        done;
    logic        err;
    logic        busy;
    logic        setf;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready;
  logic [3:0]  cmd_op;
  logic [4:0]  cmd_rd, cmd_rn, cmd_rm;
  logic [63:0] cmd_imm;
  logic [3:0]  status;
  logic [24:0] ControlWord;
  logic [63:0] constant;
  logic [3:0]  flags;
  logic        done, err, busy;

  exp_t       sb[$];
  logic [3:0] exp_flags = 4'b0;
  logic       exp_ready = 1'b1;
  int         total = 0;
  int         bad = 0;

  legv8_op_sequencer dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rn(cmd_rn), .cmd_rm(cmd_rm),
    .cmd_imm(cmd_imm), .status(status), .ControlWord(ControlWord),
    .constant(constant), .flags(flags), .done(done), .err(err), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, want, $time);
    end
  endtask

  function automatic logic [24:0] word(input logic [4:0] sa, sb_, da, input logic rw, mw,
                                       input logic [4:0] fs, input logic bsel, enm, ena);
    return {sa, sb_, da, rw, mw, fs, bsel, enm, ena};
  endfunction

  function automatic logic [4:0] fs_of(input logic [3:0] op);
    case (op)
      4'd4:              return 5'b00000;
      4'd5:              return 5'b00100;
      4'd6:              return 5'b01100;
      4'd3, 4'd8, 4'd14: return 5'b01010;
      4'd9:              return 5'b10000;
      4'd10:             return 5'b10100;
      default:           return 5'b01000;
    endcase
  endfunction

  // Reference: expected bus contents for each cycle an accepted op occupies.
  task automatic model(input logic [3:0] op, input logic [4:0] rd, rn, rm, input logic [63:0] imm);
    case (op)
      4'd0:  sb.push_back('{25'b0, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0});
      4'd1:  sb.push_back('{word(5'd31, 5'd0, rd, 1, 0, 5'b01000, 1, 0, 1), imm, 1'b1, 1'b0, 1'b0, 1'b0});
      4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd13, 4'd14:
        sb.push_back('{word(rn, rm, rd, 1, 0, fs_of(op), 0, 0, 1), 64'd0, 1'b1, 1'b0, 1'b0,
                       (op == 4'd13 || op == 4'd14)});
      4'd7, 4'd8: sb.push_back('{word(rn, 5'd0, rd, 1, 0, fs_of(op), 1, 0, 1), imm, 1'b1, 1'b0, 1'b0, 1'b0});
      4'd9, 4'd10: sb.push_back('{word(rn, 5'd0, rd, 1, 0, fs_of(op), 1, 0, 1), imm % 64, 1'b1, 1'b0, 1'b0, 1'b0});
      4'd11: sb.push_back('{word(rn, rd, 5'd0, 0, 1, 5'b01000, 1, 1, 0), imm, 1'b1, 1'b0, 1'b0, 1'b0});
      4'd12: begin
        sb.push_back('{word(rn, 5'd0, 5'd0, 0, 0, 5'b01000, 1, 0, 0), imm, 1'b0, 1'b0, 1'b1, 1'b0});
        sb.push_back('{word(rn, 5'd0, rd, 1, 0, 5'b01000, 1, 1, 0), imm, 1'b1, 1'b0, 1'b0, 1'b0});
      end
      default: sb.push_back('{25'b0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0});
    endcase
  endtask

  // Monitor: one comparison set per falling edge.
  initial begin
    exp_t r;
    forever begin
      @(negedge clock);
      if (!reset) begin
        sb.delete();
        exp_flags = 4'b0;
      end else begin
        check("flags", 64'(flags), 64'(exp_flags));
        if (ControlWord != 25'b0 || done || err || busy) begin
          if (sb.size() == 0) begin
            check("spurious_out", 64'({ControlWord, done, err, busy}), 64'd0);
          end else begin
            r = sb.pop_front();
            check("cw", 64'(ControlWord), 64'(r.cw));
            check("constant", constant, r.k);
            check("done", 64'(done), 64'(r.done));
            check("err", 64'(err), 64'(r.err));
            check("busy", 64'(busy), 64'(r.busy));
            if (r.setf) exp_flags = status;
          end
        end else begin
          check("idle_const", constant, 64'd0);
          if (sb.size() != 0) begin
            check("missing_out", 64'(sb.size()), 64'd0);
            sb.delete();
          end
        end
      end
    end
  end

  task automatic idle(input int n, input logic [3:0] st);
    for (int i = 0; i < n; i++) begin
      cmd_valid = 1'b0;
      cmd_op  = 4'($urandom_range(0, 15));
      cmd_rd  = 5'($urandom_range(0, 31));
      cmd_imm = {$urandom, $urandom};
      status  = st;
      check("cmd_ready", 64'(cmd_ready), 64'(exp_ready));
      @(posedge clock); #1;
      exp_ready = 1'b1;
    end
  endtask

  // Holds the command until the model says it is accepted (bounded).
  task automatic send(input logic [3:0] op, input logic [4:0] rd, rn, rm,
                      input logic [63:0] imm, input logic [3:0] st);
    logic acc;
    acc = 1'b0;
    cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_rn = rn; cmd_rm = rm;
    cmd_imm = imm; status = st;
    for (int t = 0; t < 4 && !acc; t++) begin
      check("cmd_ready", 64'(cmd_ready), 64'(exp_ready));
      acc = exp_ready;
      @(posedge clock); #1;
      exp_ready = 1'b1;
      if (acc) begin
        model(op, rd, rn, rm, imm);
        if (op == 4'd12) exp_ready = 1'b0;
      end
    end
    if (!acc) check("accept_timeout", 64'(acc), 64'd1);
  endtask

  task automatic rand_cycle();
    logic v, acc;
    v = ($urandom_range(0, 3) != 0);
    cmd_valid = v;
    cmd_op  = 4'($urandom_range(0, 15));
    cmd_rd  = 5'($urandom_range(0, 31));
    cmd_rn  = 5'($urandom_range(0, 31));
    cmd_rm  = 5'($urandom_range(0, 31));
    cmd_imm = {$urandom, $urandom};
    status  = 4'($urandom_range(0, 15));
    check("cmd_ready", 64'(cmd_ready), 64'(exp_ready));
    acc = v && exp_ready;
    @(posedge clock); #1;
    exp_ready = 1'b1;
    if (acc) begin
      model(cmd_op, cmd_rd, cmd_rn, cmd_rm, cmd_imm);
      if (cmd_op == 4'd12) exp_ready = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_rd = '0; cmd_rn = '0; cmd_rm = '0;
    cmd_imm = '0; status = '0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_cw", 64'(ControlWord), 64'd0);
    check("rst_const", constant, 64'd0);
    check("rst_flags", 64'(flags), 64'd0);
    check("rst_pulses", 64'({done, err, busy}), 64'd0);
    check("rst_ready", 64'(cmd_ready), 64'd1);
    reset = 1'b1;
    idle(1, 4'h0);

    send(4'd1, 5'd5, 5'd0, 5'd0, 64'd4, 4'h0);
    idle(2, 4'h0);
    send(4'd2, 5'd5, 5'd2, 5'd0, 64'd0, 4'h0);
    send(4'd3, 5'd30, 5'd15, 5'd12, 64'd0, 4'h0);
    idle(1, 4'h0);
    send(4'd11, 5'd2, 5'd1, 5'd0, 64'd0, 4'h0);
    idle(1, 4'h0);
    send(4'd12, 5'd3, 5'd1, 5'd0, 64'd8, 4'h0);
    send(4'd2, 5'd1, 5'd3, 5'd3, 64'd0, 4'h0);
    idle(2, 4'h0);
    send(4'd14, 5'd0, 5'd15, 5'd15, 64'd0, 4'h0);
    send(4'd2, 5'd7, 5'd1, 5'd2, 64'd0, 4'b1001);
    idle(1, 4'b0000);
    check("flags_held", 64'(flags), 64'h9);
    send(4'd15, 5'd1, 5'd2, 5'd3, 64'd77, 4'h0);
    send(4'd0, 5'd0, 5'd0, 5'd0, 64'd0, 4'h0);
    send(4'd9, 5'd31, 5'd31, 5'd0, 64'hFFFF_FFFF_FFFF_FFC5, 4'h0);
    send(4'd13, 5'd4, 5'd31, 5'd8, 64'd0, 4'h0);
    idle(2, 4'b0110);

    for (int i = 0; i < 400; i++) rand_cycle();
    idle(3, 4'h0);

    // Reset lands during the LDUR address cycle.
    send(4'd12, 5'd9, 5'd4, 5'd0, 64'h100, 4'h0);
    reset = 1'b0;
    #1;
    check("midrst_cw", 64'(ControlWord), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    exp_ready = 1'b1;
    cmd_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("midrst_no_wb", 64'(ControlWord), 64'd0);
    reset = 1'b1;
    idle(3, 4'h0);

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
